// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
//   Puts two plain AHB-Lite masters (M0 = CPU data port, M1 = DMA/Ethernet
//   style master) in front of one AHB-Lite master port. Neither master has
//   request/grant signals. The master that loses arbitration has its address
//   phase captured in a pending register and replayed later. Until then it is
//   held off through its own HREADY, so it only ever sees a normal wait state.
//
// Parameters
//   ARB_MODE   0: round-robin per transfer, 1: fixed priority (M0 always wins)
//
// Ports
//   HCLK, HRESET                     bus clock, asynchronous active-high reset
//   Mi_HTRANS/HADDR/HWRITE/HWDATA    upstream master address/data (i = 0, 1)
//   Mi_HRDATA/HREADY/HRESP           upstream master responses
//   HTRANS/HADDR/HWRITE/HWDATA       downstream port (NONSEQ or IDLE only)
//   HRDATA/HREADY/HRESP              downstream responses
//
//   The downstream address phase and the upstream HREADYs are combinational,
//   so an uncontested transfer passes through with no added latency.
module ahb_master_arbiter #(
  parameter bit ARB_MODE = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,

  input  logic [1:0]  M0_HTRANS,
  input  logic [31:0] M0_HADDR,
  input  logic        M0_HWRITE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,

  input  logic [1:0]  M1_HTRANS,
  input  logic [31:0] M1_HADDR,
  input  logic        M1_HWRITE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,

  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Registered state
  logic [NM-1:0]         r_pend_valid;
  logic [NM-1:0][AW-1:0] r_pend_addr;
  logic [NM-1:0]         r_pend_write;
  logic                  r_dvalid;
  logic                  r_dsel;
  logic                  r_last;

  // Next-state values
  logic [NM-1:0]         w_pend_valid_nxt;
  logic [NM-1:0][AW-1:0] w_pend_addr_nxt;
  logic [NM-1:0]         w_pend_write_nxt;
  logic                  w_dvalid_nxt;
  logic                  w_dsel_nxt;
  logic                  w_last_nxt;

  // Per-master combinational view
  logic [NM-1:0][AW-1:0] w_maddr;
  logic [NM-1:0]         w_mwrite;
  logic [NM-1:0]         w_mtrans;
  logic [NM-1:0]         w_mready;
  logic [NM-1:0]         w_live;
  logic [NM-1:0]         w_req;
  logic                  w_gnt;
  logic                  w_gnt_pend;
  logic                  w_issue;
  logic                  w_unused;

  assign w_maddr  = {M1_HADDR, M0_HADDR};
  assign w_mwrite = {M1_HWRITE, M0_HWRITE};
  assign w_mtrans = {M1_HTRANS[1], M0_HTRANS[1]};

  // HTRANS[0] only distinguishes SEQ from NONSEQ; every issue is NONSEQ.
  assign w_unused = ^{M0_HTRANS[0], M1_HTRANS[0]};

  // Per-master ready: data-phase owner follows the bus, a master with a
  // pending transfer is stalled, everyone else is free to present an address.
  always_comb begin
    w_mready = '1;
    for (int i = 0; i < int'(NM); i++) begin
      if (r_dvalid && (r_dsel == 1'(i))) begin
        w_mready[i] = HREADY;
      end else if (r_pend_valid[i]) begin
        w_mready[i] = 1'b0;
      end
    end
  end

  // A live address is only seen while the master is ready, which can never
  // happen while its pending register is full.
  assign w_live  = w_mtrans & w_mready;
  assign w_req   = r_pend_valid | w_live;
  assign w_issue = HREADY & (|w_req);

  // Grant selection
  always_comb begin
    w_gnt = 1'b0;
    if (w_req[0] && w_req[1]) begin
      if (ARB_MODE) begin
        w_gnt = 1'b0;
      end else begin
        w_gnt = ~r_last;
      end
    end else if (w_req[1]) begin
      w_gnt = 1'b1;
    end
  end

  assign w_gnt_pend = r_pend_valid[w_gnt];

  // Downstream address phase: replay the pending copy if there is one,
  // otherwise forward the winner's live address.
  always_comb begin
    HTRANS = TRANS_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    if (w_issue) begin
      HTRANS = TRANS_NONSEQ;
      if (w_gnt_pend) begin
        HADDR  = r_pend_addr[w_gnt];
        HWRITE = r_pend_write[w_gnt];
      end else begin
        HADDR  = w_maddr[w_gnt];
        HWRITE = w_mwrite[w_gnt];
      end
    end
  end

  // Pending capture/clear and data-phase tracking
  always_comb begin
    w_pend_valid_nxt = r_pend_valid;
    w_pend_addr_nxt  = r_pend_addr;
    w_pend_write_nxt = r_pend_write;
    w_dvalid_nxt     = r_dvalid;
    w_dsel_nxt       = r_dsel;
    w_last_nxt       = r_last;

    for (int i = 0; i < int'(NM); i++) begin
      if (w_live[i] && !(w_issue && (w_gnt == 1'(i)) && !r_pend_valid[i])) begin
        // Accepted from the master's point of view but not forwarded now.
        w_pend_valid_nxt[i] = 1'b1;
        w_pend_addr_nxt[i]  = w_maddr[i];
        w_pend_write_nxt[i] = w_mwrite[i];
      end else if (w_issue && (w_gnt == 1'(i)) && r_pend_valid[i]) begin
        w_pend_valid_nxt[i] = 1'b0;
      end
    end

    if (w_issue) begin
      w_dvalid_nxt = 1'b1;
      w_dsel_nxt   = w_gnt;
      w_last_nxt   = w_gnt;
    end else if (HREADY) begin
      w_dvalid_nxt = 1'b0;
    end
  end

  // State register; last resets to M1 so M0 wins the first tie.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pend_valid <= '0;
      r_pend_addr  <= '0;
      r_pend_write <= '0;
      r_dvalid     <= 1'b0;
      r_dsel       <= 1'b0;
      r_last       <= 1'b1;
    end else begin
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
      r_pend_write <= w_pend_write_nxt;
      r_dvalid     <= w_dvalid_nxt;
      r_dsel       <= w_dsel_nxt;
      r_last       <= w_last_nxt;
    end
  end

  // Data phase: write data from the owner, read data broadcast, response
  // only to the owner. Masters hold HWDATA while stalled.
  assign HWDATA    = r_dvalid ? (r_dsel ? M1_HWDATA : M0_HWDATA) : DW'(0);
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;
  assign M0_HREADY = w_mready[0];
  assign M1_HREADY = w_mready[1];
  assign M0_HRESP  = r_dvalid & ~r_dsel & HRESP;
  assign M1_HRESP  = r_dvalid &  r_dsel & HRESP;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: two master models with per-master scoreboard
// queues, a small RAM slave with controllable wait states, and one DUT per
// arbitration mode (the slave follows whichever instance is selected).
module tb_ahb_master_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  logic HRESET;

  // Master-driven inputs (shared by both DUTs)
  logic [1:0]  m_htrans [2];
  logic [31:0] m_haddr  [2];
  logic        m_hwrite [2];
  logic [31:0] m_hwdata [2];

  // Slave side
  logic        tb_stall, tb_resp;
  logic        s_hready, s_hresp;
  logic [31:0] s_hrdata;

  // DUT outputs: a_* round-robin instance, b_* fixed-priority instance
  logic [1:0]  a_htrans, b_htrans;
  logic [31:0] a_haddr, b_haddr, a_hwdata, b_hwdata;
  logic        a_hwrite, b_hwrite;
  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic        a_rdy0, a_rdy1, b_rdy0, b_rdy1, a_rsp0, a_rsp1, b_rsp0, b_rsp1;

  logic        sel;
  logic [1:0]  x_htrans;
  logic [31:0] x_haddr, x_hwdata;
  logic        x_hwrite;
  logic [31:0] x_rdata [2];
  logic [1:0]  x_rdy, x_resp;

  assign x_htrans   = sel ? b_htrans : a_htrans;
  assign x_haddr    = sel ? b_haddr  : a_haddr;
  assign x_hwrite   = sel ? b_hwrite : a_hwrite;
  assign x_hwdata   = sel ? b_hwdata : a_hwdata;
  assign x_rdata[0] = sel ? b_rd0 : a_rd0;
  assign x_rdata[1] = sel ? b_rd1 : a_rd1;
  assign x_rdy      = sel ? {b_rdy1, b_rdy0} : {a_rdy1, a_rdy0};
  assign x_resp     = sel ? {b_rsp1, b_rsp0} : {a_rsp1, a_rsp0};

  // Internal state, used only for the invariant checks
  logic [1:0]  i_pv;
  logic        i_dv, i_ds;
  logic [31:0] i_pa [2];
  assign i_pv    = sel ? u1.r_pend_valid   : u0.r_pend_valid;
  assign i_dv    = sel ? u1.r_dvalid       : u0.r_dvalid;
  assign i_ds    = sel ? u1.r_dsel         : u0.r_dsel;
  assign i_pa[0] = sel ? u1.r_pend_addr[0] : u0.r_pend_addr[0];
  assign i_pa[1] = sel ? u1.r_pend_addr[1] : u0.r_pend_addr[1];

  ahb_master_arbiter #(.ARB_MODE(1'b0)) u0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HTRANS(m_htrans[0]), .M0_HADDR(m_haddr[0]), .M0_HWRITE(m_hwrite[0]), .M0_HWDATA(m_hwdata[0]),
    .M0_HRDATA(a_rd0), .M0_HREADY(a_rdy0), .M0_HRESP(a_rsp0),
    .M1_HTRANS(m_htrans[1]), .M1_HADDR(m_haddr[1]), .M1_HWRITE(m_hwrite[1]), .M1_HWDATA(m_hwdata[1]),
    .M1_HRDATA(a_rd1), .M1_HREADY(a_rdy1), .M1_HRESP(a_rsp1),
    .HTRANS(a_htrans), .HADDR(a_haddr), .HWRITE(a_hwrite), .HWDATA(a_hwdata),
    .HRDATA(s_hrdata), .HREADY(s_hready), .HRESP(s_hresp)
  );

  ahb_master_arbiter #(.ARB_MODE(1'b1)) u1 (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HTRANS(m_htrans[0]), .M0_HADDR(m_haddr[0]), .M0_HWRITE(m_hwrite[0]), .M0_HWDATA(m_hwdata[0]),
    .M0_HRDATA(b_rd0), .M0_HREADY(b_rdy0), .M0_HRESP(b_rsp0),
    .M1_HTRANS(m_htrans[1]), .M1_HADDR(m_haddr[1]), .M1_HWRITE(m_hwrite[1]), .M1_HWDATA(m_hwdata[1]),
    .M1_HRDATA(b_rd1), .M1_HREADY(b_rdy1), .M1_HRESP(b_rsp1),
    .HTRANS(b_htrans), .HADDR(b_haddr), .HWRITE(b_hwrite), .HWDATA(b_hwdata),
    .HRDATA(s_hrdata), .HREADY(s_hready), .HRESP(s_hresp)
  );

  // Initial RAM contents
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return (a == 32'h10) ? 32'hCAFEF00D : (32'h5A5A_0000 ^ a);
  endfunction

  // RAM slave
  logic [31:0] mem [0:255];
  logic        s_dv, s_wr;
  logic [31:0] s_addr;
  assign s_hready = ~tb_stall;
  assign s_hresp  = tb_resp;
  assign s_hrdata = (s_dv && !s_wr) ? mem[s_addr[9:2]] : 32'h0;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s_dv   <= 1'b0;
      s_wr   <= 1'b0;
      s_addr <= 32'h0;
      for (int k = 0; k < 256; k++) mem[k] <= ram_init(32'(k * 4));
    end else if (s_hready) begin
      if (s_dv && s_wr) mem[s_addr[9:2]] <= x_hwdata;
      s_dv   <= x_htrans[1];
      s_addr <= x_haddr;
      s_wr   <= x_hwrite;
    end
  end

  // Master models and scoreboard
  xfer_t       mq    [2][$];
  logic [31:0] exp_q [2][$];
  logic [31:0] iss_log [$];
  logic        dph_v    [2];
  logic        dph_wr   [2];
  logic [31:0] dph_data [2];
  logic        prev_pv  [2];
  logic [31:0] prev_pa  [2];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic push(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
    xfer_t t;
    t.addr = a; t.wr = w; t.data = d;
    mq[m].push_back(t);
  endtask

  task automatic master_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      exp_q[m].delete();
      dph_v[m]    = 1'b0;
      dph_wr[m]   = 1'b0;
      dph_data[m] = 32'h0;
      prev_pv[m]  = 1'b0;
      prev_pa[m]  = 32'h0;
      m_htrans[m] = 2'b00;
      m_haddr[m]  = 32'h0;
      m_hwrite[m] = 1'b0;
      m_hwdata[m] = 32'h0;
    end
  endtask

  // One bus cycle: drive at negedge, evaluate the cycle 2 ns later.
  task automatic step(input logic stall, input logic resp);
    xfer_t t;
    logic [31:0] e;
    @(negedge HCLK);
    tb_stall = stall;
    tb_resp  = resp;
    for (int m = 0; m < 2; m++) begin
      if (mq[m].size() != 0) begin
        m_htrans[m] = 2'b10;
        m_haddr[m]  = mq[m][0].addr;
        m_hwrite[m] = mq[m][0].wr;
      end else begin
        m_htrans[m] = 2'b00;
        m_haddr[m]  = 32'h0;
        m_hwrite[m] = 1'b0;
      end
      m_hwdata[m] = dph_v[m] ? dph_data[m] : 32'h0;
    end
    #2;
    cyc++;
    if (x_htrans == 2'b10 && s_hready) iss_log.push_back(x_haddr);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (i_pv[m] && i_dv && (i_ds == 1'(m))) begin
        errors++;
        $display("FAIL pend_dsel_excl m%0d cycle %0d: pend_valid and data-phase owner both set", m, cyc);
      end
      checks++;
      if (prev_pv[m] && i_pv[m] && (i_pa[m] !== prev_pa[m])) begin
        errors++;
        $display("FAIL pend_overwrite m%0d cycle %0d: addr %0h was %0h", m, cyc, i_pa[m], prev_pa[m]);
      end
      prev_pv[m] = i_pv[m];
      prev_pa[m] = i_pa[m];
      // Data phase completes for this master
      if (dph_v[m] && x_rdy[m]) begin
        if (!dph_wr[m]) begin
          checks++;
          if (exp_q[m].size() == 0) begin
            errors++;
            $display("FAIL rdata_m%0d cycle %0d: got %0h with no expected entry", m, cyc, x_rdata[m]);
          end else begin
            e = exp_q[m].pop_front();
            if (x_rdata[m] !== e) begin
              errors++;
              $display("FAIL rdata_m%0d cycle %0d: got %0h expected %0h", m, cyc, x_rdata[m], e);
            end
          end
        end
        dph_v[m] = 1'b0;
      end
      // Address phase accepted from this master's point of view
      if (m_htrans[m][1] && x_rdy[m]) begin
        t = mq[m].pop_front();
        dph_v[m]    = 1'b1;
        dph_wr[m]   = t.wr;
        dph_data[m] = t.data;
        if (!t.wr) exp_q[m].push_back(ram_init(t.addr));
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((mq[0].size() != 0 || mq[1].size() != 0 || dph_v[0] || dph_v[1]) && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (mq[0].size() != 0 || mq[1].size() != 0 || dph_v[0] || dph_v[1]) begin
      errors++;
      $display("FAIL drain_timeout: masters still busy after %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESET   = 1'b1;
    tb_stall = 1'b0;
    tb_resp  = 1'b0;
    master_reset();
    iss_log.delete();
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    master_reset();
    repeat (2) @(negedge HCLK);
    #2;
    checks++; if (x_htrans !== 2'b00)  begin errors++; $display("FAIL reset_htrans: got %0h expected 0", x_htrans); end
    checks++; if (x_haddr !== 32'h0)   begin errors++; $display("FAIL reset_haddr: got %0h expected 0", x_haddr); end
    checks++; if (x_hwrite !== 1'b0)   begin errors++; $display("FAIL reset_hwrite: got %0h expected 0", x_hwrite); end
    checks++; if (x_hwdata !== 32'h0)  begin errors++; $display("FAIL reset_hwdata: got %0h expected 0", x_hwdata); end
    checks++; if (x_rdy !== 2'b11)     begin errors++; $display("FAIL reset_mready: got %0b expected 11", x_rdy); end
    checks++; if (x_resp !== 2'b00)    begin errors++; $display("FAIL reset_mresp: got %0b expected 00", x_resp); end
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic test_uncontested();
    do_reset();
    push(0, 32'h10, 1'b0, 32'h0);
    step(1'b0, 1'b0);
    checks++; if (x_htrans !== 2'b10)  begin errors++; $display("FAIL unc_htrans: got %0h expected 2", x_htrans); end
    checks++; if (x_haddr !== 32'h10)  begin errors++; $display("FAIL unc_haddr: got %0h expected 10", x_haddr); end
    checks++; if (x_rdy[1] !== 1'b1)   begin errors++; $display("FAIL unc_m1_ready_c0: got %0b expected 1", x_rdy[1]); end
    step(1'b0, 1'b0);
    checks++; if (x_rdata[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL unc_rdata: got %0h expected cafef00d", x_rdata[0]); end
    checks++; if (exp_q[0].size() != 0) begin errors++; $display("FAIL unc_latency: %0d reads outstanding expected 0", exp_q[0].size()); end
    checks++; if (x_rdy[1] !== 1'b1)   begin errors++; $display("FAIL unc_m1_ready_c1: got %0b expected 1", x_rdy[1]); end
  endtask

  task automatic test_simul_writes();
    sel = 1'b0;
    do_reset();
    push(0, 32'h20, 1'b1, 32'h11);
    push(1, 32'h24, 1'b1, 32'h22);
    step(1'b0, 1'b0);
    checks++; if (x_haddr !== 32'h20 || x_hwrite !== 1'b1) begin errors++; $display("FAIL sw_c0_addr: got %0h/%0b expected 20/1", x_haddr, x_hwrite); end
    checks++; if (x_rdy[1] !== 1'b1)   begin errors++; $display("FAIL sw_c0_m1_ready: got %0b expected 1", x_rdy[1]); end
    step(1'b0, 1'b0);
    checks++; if (x_haddr !== 32'h24 || x_htrans !== 2'b10) begin errors++; $display("FAIL sw_c1_addr: got %0h/%0h expected 24/2", x_haddr, x_htrans); end
    checks++; if (x_rdy[1] !== 1'b0)   begin errors++; $display("FAIL sw_c1_m1_ready: got %0b expected 0", x_rdy[1]); end
    checks++; if (x_hwdata !== 32'h11) begin errors++; $display("FAIL sw_c1_hwdata: got %0h expected 11", x_hwdata); end
    step(1'b0, 1'b0);
    checks++; if (x_rdy[1] !== 1'b1)   begin errors++; $display("FAIL sw_c2_m1_ready: got %0b expected 1", x_rdy[1]); end
    checks++; if (x_hwdata !== 32'h22) begin errors++; $display("FAIL sw_c2_hwdata: got %0h expected 22", x_hwdata); end
    step(1'b0, 1'b0);
    checks++; if (mem[8] !== 32'h11)   begin errors++; $display("FAIL sw_ram_20: got %0h expected 11", mem[8]); end
    checks++; if (mem[9] !== 32'h22)   begin errors++; $display("FAIL sw_ram_24: got %0h expected 22", mem[9]); end
  endtask

  task automatic check_order(input logic [31:0] exp_ord [8], input string tag);
    checks++;
    if (iss_log.size() != 8) begin
      errors++;
      $display("FAIL %s_count: got %0d issues expected 8", tag, iss_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (iss_log[i] !== exp_ord[i]) begin
          errors++;
          $display("FAIL %s_order[%0d]: got %0h expected %0h", tag, i, iss_log[i], exp_ord[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ord [8];
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h40 + 32'(i * 4), 1'b0, 32'h0);
      push(1, 32'h80 + 32'(i * 4), 1'b0, 32'h0);
    end
    exp_ord = '{32'h40, 32'h80, 32'h44, 32'h84, 32'h48, 32'h88, 32'h4C, 32'h8C};
    drain(40);
    check_order(exp_ord, "rr");
  endtask

  task automatic test_fixed_priority();
    logic [31:0] exp_ord [8];
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h50 + 32'(i * 4), 1'b0, 32'h0);
      push(1, 32'h90 + 32'(i * 4), 1'b0, 32'h0);
    end
    exp_ord = '{32'h50, 32'h54, 32'h58, 32'h5C, 32'h90, 32'h94, 32'h98, 32'h9C};
    drain(40);
    check_order(exp_ord, "fp");
    sel = 1'b0;
  endtask

  task automatic test_wait_states();
    sel = 1'b0;
    do_reset();
    push(0, 32'h60, 1'b0, 32'h0);
    step(1'b0, 1'b0);
    checks++; if (x_htrans !== 2'b10 || x_haddr !== 32'h60) begin errors++; $display("FAIL ws_c0: got %0h/%0h expected 2/60", x_htrans, x_haddr); end
    push(1, 32'h64, 1'b1, 32'h33);
    step(1'b1, 1'b0);
    checks++; if (x_htrans !== 2'b00)  begin errors++; $display("FAIL ws_c1_htrans: got %0h expected 0", x_htrans); end
    checks++; if (x_rdy[0] !== 1'b0)   begin errors++; $display("FAIL ws_c1_m0_ready: got %0b expected 0", x_rdy[0]); end
    step(1'b1, 1'b1);
    checks++; if (x_htrans !== 2'b00)  begin errors++; $display("FAIL ws_c2_htrans: got %0h expected 0", x_htrans); end
    checks++; if (x_rdy[1] !== 1'b0)   begin errors++; $display("FAIL ws_c2_m1_ready: got %0b expected 0", x_rdy[1]); end
    checks++; if (x_resp !== 2'b01)    begin errors++; $display("FAIL ws_hresp_route: got %0b expected 01", x_resp); end
    step(1'b1, 1'b0);
    checks++; if (x_htrans !== 2'b00)  begin errors++; $display("FAIL ws_c3_htrans: got %0h expected 0", x_htrans); end
    step(1'b0, 1'b0);
    checks++; if (x_htrans !== 2'b10 || x_haddr !== 32'h64 || x_hwrite !== 1'b1) begin
      errors++; $display("FAIL ws_c4_issue: got %0h/%0h/%0b expected 2/64/1", x_htrans, x_haddr, x_hwrite);
    end
    drain(10);
    step(1'b0, 1'b0);
    checks++; if (mem[25] !== 32'h33)  begin errors++; $display("FAIL ws_ram_64: got %0h expected 33", mem[25]); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    push(0, 32'h70, 1'b0, 32'h0);
    push(1, 32'h74, 1'b0, 32'h0);
    step(1'b0, 1'b0);
    @(posedge HCLK);
    #1;
    checks++; if (i_pv[1] !== 1'b1 || i_dv !== 1'b1) begin errors++; $display("FAIL rm_precond: pend1=%0b dvalid=%0b expected 1/1", i_pv[1], i_dv); end
    HRESET = 1'b1;
    master_reset();
    #1;
    checks++; if (x_htrans !== 2'b00)  begin errors++; $display("FAIL rm_htrans: got %0h expected 0", x_htrans); end
    checks++; if (x_haddr !== 32'h0)   begin errors++; $display("FAIL rm_haddr: got %0h expected 0", x_haddr); end
    checks++; if (x_hwdata !== 32'h0)  begin errors++; $display("FAIL rm_hwdata: got %0h expected 0", x_hwdata); end
    checks++; if (x_rdy !== 2'b11)     begin errors++; $display("FAIL rm_mready: got %0b expected 11", x_rdy); end
    checks++; if (x_resp !== 2'b00)    begin errors++; $display("FAIL rm_mresp: got %0b expected 00", x_resp); end
    @(negedge HCLK);
    HRESET = 1'b0;
    push(0, 32'h78, 1'b0, 32'h0);
    push(1, 32'h7C, 1'b0, 32'h0);
    step(1'b0, 1'b0);
    checks++; if (x_htrans !== 2'b10 || x_haddr !== 32'h78) begin errors++; $display("FAIL rm_first_tie: got %0h/%0h expected 2/78", x_htrans, x_haddr); end
    drain(20);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel      = 1'b0;
    tb_stall = 1'b0;
    tb_resp  = 1'b0;
    HRESET   = 1'b1;
    test_reset();
    test_uncontested();
    test_simul_writes();
    test_back_to_back();
    test_fixed_priority();
    test_wait_states();
    test_reset_mid();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (exp_q[m].size() != 0) begin
        errors++;
        $display("FAIL scoreboard_m%0d: %0d reads undelivered expected 0", m, exp_q[m].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
